// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand register with capture-time forwarding and hold snoop
module alu_operand_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alusrc,
    input  logic [3:0]      id_aluop,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            exm_regwrite,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_regwrite,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic [3:0]      ALUop,
    output logic [XLEN-1:0] store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_regwrite
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    logic [REGW-1:0] h_rs1;
    logic [REGW-1:0] h_rs2;
    logic [REGW-1:0] h_rd;
    logic [XLEN-1:0] h_v1;
    logic [XLEN-1:0] h_v2;
    logic [XLEN-1:0] h_imm;
    logic            h_alusrc;
    logic            h_regwrite;
    logic [3:0]      h_aluop;

    logic            capture;
    logic            transfer;
    logic            hold;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign ex_valid = (state == FULL);
    assign id_ready = !ex_valid || ex_ready;
    assign capture  = id_valid && id_ready && !flush;
    assign transfer = ex_valid && ex_ready;
    assign hold     = ex_valid && !ex_ready;

    // Resolve source operands at capture: EX/MEM beats MEM/WB, x0 always reads the regfile
    always_comb begin
        fwd1 = id_rs1_data;
        fwd2 = id_rs2_data;
        if (exm_regwrite && exm_rd == id_rs1 && id_rs1 != '0)
            fwd1 = exm_data;
        else if (wb_regwrite && wb_rd == id_rs1 && id_rs1 != '0)
            fwd1 = wb_data;
        if (exm_regwrite && exm_rd == id_rs2 && id_rs2 != '0)
            fwd2 = exm_data;
        else if (wb_regwrite && wb_rd == id_rs2 && id_rs2 != '0)
            fwd2 = wb_data;
    end

    // Occupancy: flush wins, then capture refills, else a transfer drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (capture) begin
            state <= FULL;
        end else if (transfer) begin
            state <= EMPTY;
        end
    end

    // Held operands: load on capture, otherwise track write-backs while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_rs1      <= '0;
            h_rs2      <= '0;
            h_rd       <= '0;
            h_v1       <= '0;
            h_v2       <= '0;
            h_imm      <= '0;
            h_alusrc   <= 1'b0;
            h_regwrite <= 1'b0;
            h_aluop    <= 4'b0000;
        end else if (capture) begin
            h_rs1      <= id_rs1;
            h_rs2      <= id_rs2;
            h_rd       <= id_rd;
            h_v1       <= fwd1;
            h_v2       <= fwd2;
            h_imm      <= id_imm;
            h_alusrc   <= id_alusrc;
            h_regwrite <= id_regwrite;
            h_aluop    <= id_aluop;
        end else if (hold) begin
            if (wb_regwrite && wb_rd == h_rs1 && h_rs1 != '0)
                h_v1 <= wb_data;
            if (wb_regwrite && wb_rd == h_rs2 && h_rs2 != '0)
                h_v2 <= wb_data;
        end
    end

    assign in1         = h_v1;
    assign in2         = h_alusrc ? h_imm : h_v2;
    assign store_data  = h_v2;
    assign ALUop       = h_aluop;
    assign ex_rd       = h_rd;
    assign ex_regwrite = h_regwrite && ex_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alusrc;
    logic [3:0]  id_aluop;
    logic        id_regwrite;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [63:0] exm_data;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] in1, in2, store_data;
    logic [3:0]  ALUop;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;

    alu_operand_stage #(.XLEN(64), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .in1(in1), .in2(in2), .ALUop(ALUop), .store_data(store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] imm;
        logic        alusrc;
        logic        regwrite;
        logic [3:0]  aluop;
    } exp_t;

    exp_t sb[$];
    bit   model_full = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural operand value: newest in-flight producer of rs wins, x0 reads the file
    function automatic logic [63:0] operand(input logic [4:0] rs, input logic [63:0] file_val);
        if (rs == 5'd0) return file_val;
        if (exm_regwrite && exm_rd == rs) return exm_data;
        if (wb_regwrite && wb_rd == rs) return wb_data;
        return file_val;
    endfunction

    // Advance one clock, updating the reference model with the inputs seen at the edge
    task automatic step();
        bit   xfer, cap;
        exp_t e;
        @(posedge clk);
        xfer = model_full && ex_ready;
        cap  = id_valid && (!model_full || ex_ready) && !flush;
        if (flush) begin
            sb.delete();
            model_full = 1'b0;
        end else begin
            if (model_full && !xfer && wb_regwrite && sb.size() > 0) begin
                e = sb[0];
                if (e.rs1 != 5'd0 && e.rs1 == wb_rd) e.v1 = wb_data;
                if (e.rs2 != 5'd0 && e.rs2 == wb_rd) e.v2 = wb_data;
                sb[0] = e;
            end
            if (cap) begin
                e.rs1 = id_rs1;   e.rs2 = id_rs2;   e.rd = id_rd;
                e.v1  = operand(id_rs1, id_rs1_data);
                e.v2  = operand(id_rs2, id_rs2_data);
                e.imm = id_imm;   e.alusrc = id_alusrc;
                e.regwrite = id_regwrite;   e.aluop = id_aluop;
                sb.push_back(e);
                model_full = 1'b1;
            end else if (xfer) begin
                model_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic alusrc,
                          input logic [3:0] aluop, input logic [4:0] rd, input logic rw);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_alusrc = alusrc; id_aluop = aluop; id_rd = rd; id_regwrite = rw;
    endtask

    // Monitor: compare the held instruction against the scoreboard head, pop on transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, model_full});
            chk("id_ready", {63'd0, id_ready}, {63'd0, (!model_full || ex_ready)});
            if (!model_full)
                chk("ex_regwrite_empty", {63'd0, ex_regwrite}, 64'd0);
            if (ex_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output actual=valid expected=empty at %0t", $time);
                end else begin
                    e = sb[0];
                    chk("in1", in1, e.v1);
                    chk("in2", in2, e.alusrc ? e.imm : e.v2);
                    chk("store_data", store_data, e.v2);
                    chk("ALUop", {60'd0, ALUop}, {60'd0, e.aluop});
                    chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
                    chk("ex_regwrite", {63'd0, ex_regwrite}, {63'd0, e.regwrite});
                    if (ex_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; id_valid = 0; flush = 0; ex_ready = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exm_regwrite = 0; exm_rd = 0; exm_data = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_in1", in1, 64'd0);
        chk("rst_in2", in2, 64'd0);
        chk("rst_store", store_data, 64'd0);
        chk("rst_ALUop", {60'd0, ALUop}, 64'd0);
        chk("rst_ex_rd", {59'd0, ex_rd}, 64'd0);
        chk("rst_ex_regwrite", {63'd0, ex_regwrite}, 64'd0);
        rst = 1'b0;

        // first capture
        ex_ready = 1; id_valid = 1;
        set_id(1, 2, 64'd5, 64'd7, 64'd0, 0, 4'b0010, 5'd3, 1);
        step();
        id_valid = 0;
        chk("cap_in1", in1, 64'd5);
        chk("cap_in2", in2, 64'd7);
        step();

        // forwarding priority
        id_valid = 1;
        set_id(4, 0, 64'h11, 64'h22, 0, 0, 4'b0001, 5'd8, 1);
        exm_regwrite = 1; exm_rd = 4; exm_data = 64'hAA;
        wb_regwrite = 1;  wb_rd = 4;  wb_data = 64'hBB;
        step();
        chk("fwd_exm", in1, 64'hAA);
        exm_regwrite = 0;
        step();
        chk("fwd_wb", in1, 64'hBB);
        id_rs1 = 0; exm_regwrite = 1; exm_rd = 0; wb_rd = 0;
        step();
        chk("fwd_x0", in1, 64'h11);
        exm_regwrite = 0; wb_regwrite = 0; id_valid = 0;
        step();

        // stall snoop, alusrc=0 then alusrc=1
        for (int k = 0; k < 2; k++) begin
            ex_ready = 0; id_valid = 1;
            set_id(5'd9, 5'd6, 64'h3, 64'h1, 64'h10, k[0], 4'b0110, 5'd2, 1);
            step();
            set_id(5'd1, 5'd1, 64'h77, 64'h77, 64'h0, 0, 4'b0000, 5'd1, 1);
            wb_regwrite = 1; wb_rd = 6; wb_data = 64'h99;
            step();
            wb_regwrite = 0;
            chk("snoop_store", store_data, 64'h99);
            chk("snoop_in2", in2, k ? 64'h10 : 64'h99);
            step();
            id_valid = 0; ex_ready = 1;
            step();
            step();
        end

        // back-to-back
        ex_ready = 1; id_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            set_id(5'd0, 5'd0, 64'(k), 64'd0, 64'd0, 0, 4'b0010, 5'd1, 1);
            step();
            chk("b2b_in1", in1, 64'(k));
        end
        id_valid = 0;
        step();

        // flush while full with incoming instruction
        id_valid = 1; ex_ready = 0;
        set_id(5'd0, 5'd0, 64'h5, 64'h5, 0, 0, 4'b0111, 5'd7, 1);
        step();
        flush = 1;
        set_id(5'd0, 5'd0, 64'hDEAD, 64'h5, 0, 0, 4'b1100, 5'd9, 1);
        step();
        flush = 0; id_valid = 0;
        chk("flush_valid", {63'd0, ex_valid}, 64'd0);
        chk("flush_regwrite", {63'd0, ex_regwrite}, 64'd0);
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
            exm_regwrite = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7));
            exm_data = {$urandom, $urandom};
            wb_regwrite = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            step();
        end
        flush = 0; exm_regwrite = 0; wb_regwrite = 0;

        // async reset while holding
        id_valid = 1; ex_ready = 1;
        set_id(5'd1, 5'd2, 64'h123, 64'h456, 0, 0, 4'b0110, 5'd4, 1);
        step();
        id_valid = 0; ex_ready = 0;
        step();
        #2 rst = 1;
        #1;
        chk("arst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("arst_ALUop", {60'd0, ALUop}, 64'd0);
        chk("arst_ex_regwrite", {63'd0, ex_regwrite}, 64'd0);
        sb.delete();
        model_full = 1'b0;
        #2 rst = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
